// File: rtl/pc_unit.sv
// Program counter with priority next-PC select and an optional return-address stack.
// Define PC_UNIT_RAS_EN to build the RAS; otherwise call/ret are ignored.
module pc_unit #(
    parameter int unsigned WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] STEP = WIDTH'(1),
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             stall,
    input  logic             IncPC,
    input  logic             load,
    input  logic             branch,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] q,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ret_err
);

    logic [WIDTH-1:0] q_n;

`ifdef PC_UNIT_RAS_EN
    localparam int PW = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]    sp, sp_inc, sp_dec, sp_n;
    logic [CW-1:0]    depth, depth_n;
    logic             do_push, do_pop, do_err, ret_sel;

    assign sp_inc  = (sp == LAST) ? '0 : sp + PW'(1);
    assign sp_dec  = (sp == '0) ? LAST : sp - PW'(1);
    assign ret_sel = !stall && !load && !branch && ret;
    assign do_push = !stall && load && call;
    assign do_pop  = ret_sel && (depth != '0);
    assign do_err  = ret_sel && (depth == '0);

    always_comb begin
        q_n = q;
        if (stall)       q_n = q;
        else if (load)   q_n = d;
        else if (branch) q_n = q + offset;
        else if (ret)    q_n = do_pop ? stack[sp_dec] : q;
        else if (IncPC)  q_n = q + STEP;
    end

    // A push on a full stack wraps over the oldest slot; depth saturates.
    always_comb begin
        sp_n    = sp;
        depth_n = depth;
        if (do_push) begin
            sp_n    = sp_inc;
            depth_n = (depth == FULL) ? FULL : depth + CW'(1);
        end else if (do_pop) begin
            sp_n    = sp_dec;
            depth_n = depth - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!clear && do_push) stack[sp] <= q + STEP;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q         <= RESET_VECTOR;
            sp        <= '0;
            depth     <= '0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
            ret_err   <= 1'b0;
        end else begin
            q         <= q_n;
            sp        <= sp_n;
            depth     <= depth_n;
            ras_empty <= (depth_n == '0);
            ras_full  <= (depth_n == FULL);
            ret_err   <= do_err;
        end
    end
`else
    localparam int unused_depth = RAS_DEPTH;
    logic unused_ras;

    assign unused_ras = call ^ ret;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign ret_err    = 1'b0;

    always_comb begin
        q_n = q;
        if (stall)       q_n = q;
        else if (load)   q_n = d;
        else if (branch) q_n = q + offset;
        else if (IncPC)  q_n = q + STEP;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) q <= RESET_VECTOR;
        else       q <= q_n;
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit (RESET_VECTOR=0x100, STEP=1, RAS_DEPTH=4).
// Expectations follow whichever PC_UNIT_RAS_EN build is compiled.
module tb_pc_unit;

    typedef struct {
        logic        stall, inc, load, branch, call, ret;
        logic [31:0] d, off, eq;
        logic        ee, ef, er;
    } vec_t;

    logic        clock = 0, clear = 0;
    logic        stall = 0, IncPC = 0, load = 0, branch = 0, call = 0, ret = 0;
    logic [31:0] d = '0, offset = '0;
    logic [31:0] q;
    logic        ras_empty, ras_full, ret_err;
    int          errors = 0, checks = 0;
    vec_t        vq[$];

    pc_unit #(
        .WIDTH(32),
        .RESET_VECTOR(32'h100),
        .STEP(32'd1),
        .RAS_DEPTH(4)
    ) dut (
        .clock(clock), .clear(clear), .stall(stall), .IncPC(IncPC),
        .load(load), .branch(branch), .call(call), .ret(ret),
        .d(d), .offset(offset), .q(q),
        .ras_empty(ras_empty), .ras_full(ras_full), .ret_err(ret_err)
    );

    always #5 clock = ~clock;

    function automatic vec_t v(logic s, logic i, logic l, logic b, logic c,
                               logic r, logic [31:0] dd, logic [31:0] o,
                               logic [31:0] eq, logic ee, logic ef, logic er);
        vec_t x;
        x.stall = s; x.inc = i; x.load = l; x.branch = b; x.call = c; x.ret = r;
        x.d = dd; x.off = o; x.eq = eq; x.ee = ee; x.ef = ef; x.er = er;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        stall = x.stall; IncPC = x.inc; load = x.load; branch = x.branch;
        call = x.call; ret = x.ret; d = x.d; offset = x.off;
    endtask

    task automatic check_all(input string tag, input logic [31:0] eq,
                             input logic ee, input logic ef, input logic er);
        chk({tag, ".q"}, q, eq);
        chk({tag, ".empty"}, {31'b0, ras_empty}, {31'b0, ee});
        chk({tag, ".full"}, {31'b0, ras_full}, {31'b0, ef});
        chk({tag, ".err"}, {31'b0, ret_err}, {31'b0, er});
    endtask

    initial begin
        // Clear with no clock edge yet: async reset must take effect alone.
        #2 clear = 1;
        #1 check_all("reset", 32'h100, 1, 0, 0);
        #1 clear = 0;

        //             s i l b c r  d             off           q            e f r
        vq.push_back(v(0,1,0,0,0,0, 32'h0,        32'h0,        32'h101,     1,0,0));
        vq.push_back(v(0,1,0,0,0,0, 32'h0,        32'h0,        32'h102,     1,0,0));
        vq.push_back(v(0,1,0,0,0,0, 32'h0,        32'h0,        32'h103,     1,0,0));
        vq.push_back(v(0,0,1,0,0,0, 32'h200,      32'h0,        32'h200,     1,0,0));
        vq.push_back(v(0,0,0,1,0,0, 32'h0,        32'hFFFFFFF0, 32'h1F0,     1,0,0));
        vq.push_back(v(0,0,1,0,0,0, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF,1,0,0));
        vq.push_back(v(0,1,0,0,0,0, 32'h0,        32'h0,        32'h0,       1,0,0));
        vq.push_back(v(0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,       1,0,0));
        vq.push_back(v(0,1,1,1,0,0, 32'h10,       32'h8,        32'h10,      1,0,0));
        vq.push_back(v(0,1,0,1,0,0, 32'h0,        32'h4,        32'h14,      1,0,0));
`ifdef PC_UNIT_RAS_EN
        vq.push_back(v(0,0,1,0,0,0, 32'h10,       32'h0,        32'h10,      1,0,0));
        vq.push_back(v(0,0,1,0,1,0, 32'h80,       32'h0,        32'h80,      0,0,0));
        vq.push_back(v(0,0,0,0,0,1, 32'h0,        32'h0,        32'h11,      1,0,0));
        vq.push_back(v(0,0,0,0,0,1, 32'h0,        32'h0,        32'h11,      1,0,1));
        vq.push_back(v(0,0,0,0,0,0, 32'h0,        32'h0,        32'h11,      1,0,0));
        vq.push_back(v(0,0,1,0,0,1, 32'h0,        32'h0,        32'h0,       1,0,0));
        vq.push_back(v(0,0,1,0,1,0, 32'h1,        32'h0,        32'h1,       0,0,0));
        vq.push_back(v(0,0,1,0,1,0, 32'h2,        32'h0,        32'h2,       0,0,0));
        vq.push_back(v(0,0,1,0,1,0, 32'h3,        32'h0,        32'h3,       0,0,0));
        vq.push_back(v(0,0,1,0,1,0, 32'h4,        32'h0,        32'h4,       0,1,0));
        vq.push_back(v(0,0,1,0,1,0, 32'h99,       32'h0,        32'h99,      0,1,0));
        vq.push_back(v(0,0,0,0,0,1, 32'h0,        32'h0,        32'h5,       0,0,0));
        vq.push_back(v(0,0,0,0,0,1, 32'h0,        32'h0,        32'h4,       0,0,0));
        vq.push_back(v(0,0,0,0,0,1, 32'h0,        32'h0,        32'h3,       0,0,0));
        vq.push_back(v(0,0,0,0,0,1, 32'h0,        32'h0,        32'h2,       1,0,0));
        vq.push_back(v(0,0,0,0,0,1, 32'h0,        32'h0,        32'h2,       1,0,1));
        vq.push_back(v(0,0,0,0,0,0, 32'h0,        32'h0,        32'h2,       1,0,0));
        vq.push_back(v(0,0,1,0,1,0, 32'h30,       32'h0,        32'h30,      0,0,0));
        vq.push_back(v(1,0,1,0,0,1, 32'h77,       32'h0,        32'h30,      0,0,0));
        vq.push_back(v(1,0,0,0,0,1, 32'h0,        32'h0,        32'h30,      0,0,0));
        vq.push_back(v(0,0,0,1,0,1, 32'h0,        32'h2,        32'h32,      0,0,0));
        vq.push_back(v(0,0,0,0,0,1, 32'h0,        32'h0,        32'h3,       1,0,0));
        vq.push_back(v(1,0,0,0,0,1, 32'h0,        32'h0,        32'h3,       1,0,0));
        vq.push_back(v(0,1,0,0,1,0, 32'h0,        32'h0,        32'h4,       1,0,0));
        vq.push_back(v(0,0,0,0,0,1, 32'h0,        32'h0,        32'h4,       1,0,1));
        vq.push_back(v(0,0,0,0,0,0, 32'h0,        32'h0,        32'h4,       1,0,0));
        vq.push_back(v(0,0,1,0,1,0, 32'h50,       32'h0,        32'h50,      0,0,0));
`else
        vq.push_back(v(0,0,1,0,1,0, 32'h80,       32'h0,        32'h80,      1,0,0));
        vq.push_back(v(0,0,0,0,0,1, 32'h0,        32'h0,        32'h80,      1,0,0));
        vq.push_back(v(0,1,0,0,0,1, 32'h0,        32'h0,        32'h81,      1,0,0));
        vq.push_back(v(1,0,1,0,0,0, 32'h5,        32'h0,        32'h81,      1,0,0));
        vq.push_back(v(1,1,0,0,0,0, 32'h0,        32'h0,        32'h81,      1,0,0));
        vq.push_back(v(0,0,0,1,0,0, 32'h0,        32'hFFFFFFFF, 32'h80,      1,0,0));
        vq.push_back(v(0,0,1,0,1,0, 32'h50,       32'h0,        32'h50,      1,0,0));
`endif

        foreach (vq[i]) begin
            drive(vq[i]);
            @(posedge clock);
            #1 check_all($sformatf("row%0d", i), vq[i].eq, vq[i].ee, vq[i].ef, vq[i].er);
        end

        // Clear mid-operation, held across an edge with ret pending.
        drive(v(0,0,0,0,0,1, 32'h0, 32'h0, 32'h0, 0,0,0));
        clear = 1;
        #1 check_all("midclr", 32'h100, 1, 0, 0);
        @(posedge clock);
        #1 check_all("clrhold", 32'h100, 1, 0, 0);
        clear = 0;
        @(posedge clock);
`ifdef PC_UNIT_RAS_EN
        #1 check_all("postclr", 32'h100, 1, 0, 1);
`else
        #1 check_all("postclr", 32'h100, 1, 0, 0);
`endif
        drive(v(0,1,0,0,0,0, 32'h0, 32'h0, 32'h0, 0,0,0));
        @(posedge clock);
        #1 check_all("postinc", 32'h101, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC register width in bits.
REQ-002 Parameter RESET_VECTOR, default 0: value loaded into q on reset.
REQ-003 Parameter STEP, default 1: sequential increment amount.
REQ-004 Parameter RAS_DEPTH, default 4: return-address stack entries, legal range 2..16.
REQ-005 clock  input  1  single clock; all state changes on its rising edge.
REQ-006 clear  input  1  reset, asynchronous, active-high.
REQ-007 stall  input  1  freezes q and the return-address stack (RAS) when high.
REQ-008 IncPC  input  1  request q <= q + STEP.
REQ-009 load  input  1  request absolute jump, q <= d.
REQ-010 branch  input  1  request relative jump, q <= q + offset.
REQ-011 call  input  1  qualifier on load; pushes q + STEP to the RAS.
REQ-012 ret  input  1  request q <= top of RAS, then pop.
REQ-013 d  input  WIDTH  absolute jump target.
REQ-014 offset  input  WIDTH  two's-complement branch displacement.
REQ-015 q  output  WIDTH  current PC, registered.
REQ-016 ras_empty  output  1  RAS holds zero entries.
REQ-017 ras_full  output  1  RAS holds RAS_DEPTH entries.
REQ-018 ret_err  output  1  one-cycle pulse when ret is accepted while the RAS is empty.

Function
REQ-019 The block SHALL resolve one action per rising edge, with priority stall > load > branch > ret > IncPC; if none is asserted, q holds.
REQ-020 All q arithmetic SHALL be modulo 2^WIDTH, with silent wrap-around (for example, all-ones + STEP=1 gives 0).
REQ-021 branch SHALL add offset sign-extended to WIDTH; a negative offset moves q backward.
REQ-022 load with call SHALL write d into q and push the pre-update q + STEP onto the RAS in the same edge.
REQ-023 call without load SHALL be ignored.
REQ-024 Push when full SHALL overwrite the oldest entry (circular stack); ras_full stays 1 and the depth count does not exceed RAS_DEPTH.
REQ-025 ret with RAS non-empty SHALL write the top entry into q and decrement the depth in the same edge.
REQ-026 ret with RAS empty SHALL leave q unchanged and drive ret_err high for exactly the following cycle.
REQ-027 ret_err SHALL be registered and return to 0 on the next edge unless it is re-triggered.
REQ-028 A ret masked by a higher-priority load or branch SHALL not pop the stack and SHALL not raise ret_err.
REQ-029 stall high SHALL hold q, the RAS contents, the depth count and ras_* outputs; ret_err SHALL be 0 during stall.
REQ-030 ras_empty and ras_full SHALL be registered flags consistent with the depth count after each edge.
REQ-031 Load-to-q latency SHALL be one edge; q SHALL never change between edges except on clear.

Reset
REQ-032 clear high SHALL, without waiting for clock, set q=RESET_VECTOR, depth=0, ras_empty=1, ras_full=0, ret_err=0.
REQ-033 clear asserted mid-operation (including on the same edge as call or ret) SHALL dominate; the RAS contents become don't-care and the stack is empty.
REQ-034 After clear deasserts, the first rising edge SHALL perform the normal priority action.

Configuration
REQ-035 Macro PC_UNIT_RAS_EN defined: the RAS, call, ret and ras_* behaviour SHALL be implemented as specified above.
REQ-036 Macro PC_UNIT_RAS_EN undefined: no RAS storage SHALL exist; call and ret SHALL be ignored; ras_empty SHALL be tied to 1 and ras_full to 0; ret_err SHALL be tied to 0; the ports remain present.

Verification
REQ-037 Bench SHALL cover the following scenario: clear pulse with no clock, then IncPC for 3 edges (STEP=1, RESET_VECTOR=0x100) -> q = 0x100, 0x101, 0x102, 0x103.
REQ-038 Bench SHALL cover the following scenario: q=0x200, branch with offset=0xFFFFFFF0 -> q = 0x1F0; q=0xFFFFFFFF with IncPC -> q = 0.
REQ-039 Bench SHALL cover the following scenario: q=0x10, load+call with d=0x80, then ret -> q = 0x80, then q = 0x11, with ras_empty = 1 afterwards.
REQ-040 Bench SHALL cover the following scenario: 5 calls with RAS_DEPTH=4 from q=0,1,2,3,4, then 5 rets -> returns 5, 4, 3, 2, then ret_err pulses once and q holds.
REQ-041 Bench SHALL cover the following scenario: stall high together with load and ret -> q, depth and flags unchanged, and ret_err = 0.
REQ-042 Bench SHALL cover the following scenario: with the macro undefined, load+call then ret -> q = d and stays d, ras_empty = 1, ret_err = 0.
